// File: rtl/data_mem_responder_pkg.sv
// ============================================================================
// Module : data_mem_responder_pkg
// Brief  : Shared encodings for the MEM-stage data memory responder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_responder_pkg;

  localparam int LANE_W = 8;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module : dmem_lane_align
// Brief  : Little-endian lane handling: load extract/extend, store merge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        signExt,
  input  logic [31:0] rdWord,
  input  logic [31:0] wData,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord,
  output logic [3:0]  byteEn
);

  logic [15:0] w_shifted;
  logic [31:0] w_wRep;

  // Offset is already aligned to the access size by the caller.
  assign w_shifted = 16'(rdWord >> {offset, 3'b000});

  always_comb begin
    loadData = rdWord;
    byteEn   = 4'b1111;
    w_wRep   = wData;
    case (size)
      SIZE_BYTE: begin
        loadData = {{24{signExt & w_shifted[7]}}, w_shifted[7:0]};
        byteEn   = 4'b0001 << offset;
        w_wRep   = {4{wData[7:0]}};
      end
      SIZE_HALF: begin
        loadData = {{16{signExt & w_shifted[15]}}, w_shifted};
        byteEn   = offset[1] ? 4'b1100 : 4'b0011;
        w_wRep   = {2{wData[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar n = 0; n < 4; n++) begin : g_lane
    assign mergedWord[LANE_W*n +: LANE_W] =
      byteEn[n] ? w_wRep[LANE_W*n +: LANE_W] : rdWord[LANE_W*n +: LANE_W];
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module : data_mem_responder
// Brief  : Fixed-latency word store answering MEM-stage loads/stores.
//          DMEM_MISALIGN_CHECK_EN enables misaligned-access error reporting.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  output logic        ReqReady,
  output logic        RspValid,
  output logic [31:0] RspRData,
  output logic        RspError,
  output logic        Stall
);

  localparam int c_ADDR_W = $clog2(DEPTH_WORDS);

  state_t                r_state, w_nextState;
  logic [3:0]            r_count, w_nextCount;
  logic                  w_accept;
  logic                  r_write, r_signed, r_err;
  logic [c_ADDR_W-1:0]   r_idx;
  logic [1:0]            r_off, r_size, w_offset;
  logic [31:0]           r_wData;
  logic [31:0]           r_mem [DEPTH_WORDS];
  logic [31:0]           w_rdWord, w_load, w_merged;
  logic [3:0]            w_byteEn;
  logic                  w_reqMisalign, w_memWrite;
  logic                  w_unused;

  assign w_unused = ^ReqAddr[31:c_ADDR_W+2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_reqMisalign = (ReqSize == SIZE_HALF) ? ReqAddr[0] :
                         (ReqSize == SIZE_BYTE) ? 1'b0 : (ReqAddr[1:0] != 2'b00);
`else
  assign w_reqMisalign = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_accept    = 1'b0;
    ReqReady    = 1'b0;
    RspValid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          w_accept    = 1'b1;
          w_nextCount = 4'(LATENCY - 1);
          w_nextState = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_nextCount = r_count - 4'd1;
        if (r_count <= 4'd1) w_nextState = ST_RESP;
      end
      ST_RESP: begin
        RspValid    = 1'b1;
        w_nextCount = 4'd0;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_off    <= 2'b00;
      r_size   <= SIZE_WORD;
      r_wData  <= 32'd0;
    end else if (w_accept) begin
      r_write  <= ReqWrite;
      r_signed <= ReqSigned;
      r_err    <= w_reqMisalign;
      r_idx    <= ReqAddr[c_ADDR_W+1:2];
      r_off    <= ReqAddr[1:0];
      r_size   <= ReqSize;
      r_wData  <= ReqWData;
    end
  end

  // Low address bits are masked to the access size before lane selection.
  always_comb begin
    case (r_size)
      SIZE_BYTE: w_offset = r_off;
      SIZE_HALF: w_offset = {r_off[1], 1'b0};
      default:   w_offset = 2'b00;
    endcase
  end

  assign w_rdWord = r_mem[r_idx];

  dmem_lane_align u_align (
    .size       (r_size),
    .offset     (w_offset),
    .signExt    (r_signed),
    .rdWord     (w_rdWord),
    .wData      (r_wData),
    .loadData   (w_load),
    .mergedWord (w_merged),
    .byteEn     (w_byteEn)
  );

  assign w_memWrite = RspValid & r_write & ~r_err;

  // Reset in the RESP cycle must suppress the write, hence the Rst gate.
  always_ff @(posedge Clk) begin
    if (!Rst && w_memWrite) r_mem[r_idx] <= w_merged;
  end

  assign RspError = RspValid & r_err;
  assign RspRData = (RspValid & ~r_write & ~r_err) ? w_load : 32'd0;
  assign Stall    = (ReqValid | (r_state != ST_IDLE)) & ~RspValid;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module : tb_data_mem_responder
// Brief  : Self-checking bench with a byte-addressed reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqWrite = 1'b0;
  logic [31:0] ReqAddr = 32'd0;
  logic [31:0] ReqWData = 32'd0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqSigned = 1'b0;
  wire         ReqReady;
  wire         RspValid;
  wire  [31:0] RspRData;
  wire         RspError;
  wire         Stall;

  int checks = 0;
  int errors = 0;

  logic [7:0] mb [4096];

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqSize(ReqSize),
    .ReqSigned(ReqSigned), .ReqReady(ReqReady), .RspValid(RspValid),
    .RspRData(RspRData), .RspError(RspError), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  // Byte-level model: memory wraps at 4 KiB, accesses are 1/2/4 bytes.
  function automatic void ref_access(input bit wr, input logic [31:0] a,
      input logic [31:0] wd, input logic [1:0] sz, input bit sg,
      output logic [31:0] rd, output bit er);
    int n, base;
    logic [31:0] v;
    n = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
    base = int'(a[11:0]);
    er = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    er = (base % n) != 0;
`endif
    base = base - (base % n);
    rd = 32'd0;
    if (!er) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mb[base+i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[base+i]) << (8*i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endfunction

  // Call at a negedge; returns at the negedge of the first IDLE cycle after RESP.
  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
      input logic [1:0] sz, input bit sg, output logic [31:0] rd, output logic er);
    logic [31:0] expD;
    bit expE, got;
    ref_access(wr, a, wd, sz, sg, expD, expE);
    ReqValid = 1'b1; ReqWrite = wr; ReqAddr = a; ReqWData = wd;
    ReqSize = sz; ReqSigned = sg;
    #1;
    checks++;
    if (ReqReady !== 1'b1 || Stall !== 1'b1) begin
      errors++;
      $display("FAIL accept_cycle ReqReady=%b Stall=%b required 1 1", ReqReady, Stall);
    end
    got = 1'b0; rd = 32'd0; er = 1'b0;
    for (int c = 1; c <= LAT + 4 && !got; c++) begin
      @(negedge Clk);
      if (RspValid === 1'b1) begin
        got = 1'b1;
        rd = RspRData; er = RspError;
        checks++;
        if (c != LAT) begin
          errors++;
          $display("FAIL latency got %0d required %0d", c, LAT);
        end
        checks++;
        if (Stall !== 1'b0 || ReqReady !== 1'b0) begin
          errors++;
          $display("FAIL resp_cycle Stall=%b ReqReady=%b required 0 0", Stall, ReqReady);
        end
        checks++;
        if (RspRData !== expD) begin
          errors++;
          $display("FAIL rdata addr=%h size=%b got %h required %h", a, sz, RspRData, expD);
        end
        checks++;
        if (RspError !== expE) begin
          errors++;
          $display("FAIL rsp_error addr=%h size=%b got %b required %b", a, sz, RspError, expE);
        end
      end else if (c < LAT) begin
        checks++;
        if (Stall !== 1'b1 || ReqReady !== 1'b0 || RspValid !== 1'b0) begin
          errors++;
          $display("FAIL wait_cycle Stall=%b ReqReady=%b RspValid=%b required 1 0 0",
                   Stall, ReqReady, RspValid);
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout no RspValid got 0 required 1");
    end
    ReqValid = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if (ReqReady !== 1'b1 || Stall !== 1'b0 || RspValid !== 1'b0 ||
        RspRData !== 32'd0 || RspError !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rdy=%b stall=%b vld=%b data=%h err=%b required 1 0 0 0 0",
               ReqReady, Stall, RspValid, RspRData, RspError);
    end
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_preload();
    logic [31:0] d; logic e;
    for (int w = 0; w < 16; w++) do_txn(1'b1, 32'(w*4), $urandom, 2'b00, 1'b0, d, e);
  endtask

  task automatic test_word();
    logic [31:0] d; logic e;
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, d, e);
    do_txn(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, d, e);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_load got %h required DEADBEEF", d);
    end
  endtask

  task automatic test_extend();
    logic [31:0] d; logic e;
    do_txn(1'b1, 32'h20, 32'h11223380, 2'b00, 1'b0, d, e);
    do_txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b1, d, e);
    checks++;
    if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL sbyte got %h required FFFFFF80", d); end
    do_txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, d, e);
    checks++;
    if (d !== 32'h00000080) begin errors++; $display("FAIL ubyte got %h required 00000080", d); end
    do_txn(1'b0, 32'h22, 32'h0, 2'b01, 1'b1, d, e);
    checks++;
    if (d !== 32'h00001122) begin errors++; $display("FAIL shalf got %h required 00001122", d); end
    do_txn(1'b1, 32'h23, 32'hFFFFFFAB, 2'b10, 1'b0, d, e);
    do_txn(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, d, e);
    checks++;
    if (d !== 32'hAB223380) begin errors++; $display("FAIL partial_store got %h required AB223380", d); end
  endtask

  task automatic test_misalign();
    logic [31:0] d; logic e;
    do_txn(1'b1, 32'h21, 32'h01020304, 2'b00, 1'b0, d, e);
    do_txn(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, d, e);
    checks++;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (d !== 32'd0 || e !== 1'b1) begin
      errors++; $display("FAIL misalign got %h/%b required 00000000/1", d, e);
    end
    do_txn(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, d, e);
    checks++;
    if (d !== 32'hAB223380) begin errors++; $display("FAIL misalign_nowrite got %h required AB223380", d); end
`else
    if (d !== 32'h01020304 || e !== 1'b0) begin
      errors++; $display("FAIL misalign_masked got %h/%b required 01020304/0", d, e);
    end
`endif
  endtask

  task automatic test_reset_midop();
    logic [31:0] d, expD; logic e; bit seen; bit expE;
    do_txn(1'b1, 32'h30, 32'h12345678, 2'b00, 1'b0, d, e);
    // Abort in WAIT.
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h30; ReqWData = 32'h55; ReqSize = 2'b10;
    @(negedge Clk);
    Rst = 1'b1; ReqValid = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge Clk); if (RspValid !== 1'b0) seen = 1'b1; end
    Rst = 1'b0;
    checks++;
    if (seen) begin errors++; $display("FAIL abort_rsp got RspValid=1 required 0"); end
    @(negedge Clk);
    // Abort in RESP: write must be suppressed.
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h30; ReqWData = 32'h66; ReqSize = 2'b10;
    seen = 1'b0;
    for (int c = 0; c < LAT + 4 && !seen; c++) begin
      @(negedge Clk);
      if (RspValid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL resp_abort_timeout got 0 required 1"); end
    Rst = 1'b1; ReqValid = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    ref_access(1'b0, 32'h30, 32'h0, 2'b00, 1'b0, expD, expE);
    do_txn(1'b0, 32'h30, 32'h0, 2'b00, 1'b0, d, e);
    checks++;
    if (d !== 32'h12345678) begin errors++; $display("FAIL abort_nowrite got %h required 12345678", d); end
  endtask

  task automatic test_random();
    logic [31:0] d; logic e; logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), d, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; logic [31:0] a, v;
    for (int i = 0; i < 6; i++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      v = $urandom;
      do_txn(1'b1, a, v, 2'b00, 1'b0, d, e);
      do_txn(1'b0, a, 32'h0, 2'b00, 1'b0, d, e);
      checks++;
      if (d !== v) begin errors++; $display("FAIL raw_b2b addr=%h got %h required %h", a, d, v); end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_word();
    test_extend();
    test_misalign();
    test_reset_midop();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
